// File: rtl/opb_reg_bank_pkg.sv
// Shared definitions for the OPB register bank: register offsets, CTRL bit
// positions (OPB numbering, bit 0 = MSB) and the bus FSM state type.
package opb_reg_bank_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'h0000_0000;
    localparam logic [31:0] OFF_VALID   = 32'h0000_0004;
    localparam logic [31:0] OFF_OVF     = 32'h0000_0008;
    localparam logic [31:0] OFF_INFO    = 32'h0000_000C;
    localparam logic [31:0] OFF_CH_BASE = 32'h0000_0010;

    // CTRL bits and the byte lane carrying them, in OPB big-endian numbering
    localparam int CTRL_SNAP_BIT    = 31;
    localparam int CTRL_OVF_CLR_BIT = 30;
    localparam int CTRL_BE_LANE     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        HOLD
    } bus_state_t;

endpackage

// File: rtl/opb_reg_bank_chan.sv
// One capture channel: holding register, sticky VALID/OVF flags and, when
// OPB_REG_BANK_TIMESTAMP_EN is defined, the capture timestamp.
module opb_reg_bank_chan #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          read_clr,
    input  logic          ovf_clr,
    input  logic [W-1:0]  data_in,
    input  logic [31:0]   ts_now,
    output logic [W-1:0]  data,
    output logic          valid,
    output logic          ovf,
    output logic [31:0]   ts
);

    // NOTE: non-blocking assignments so every flag samples the pre-edge values
    // of its neighbours; blocking here would let valid update before ovf reads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                data <= data_in;
            end
            // A capture coinciding with the read that clears VALID is not an overflow
            valid <= load | (valid & ~read_clr);
            if (load && valid && !read_clr) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef OPB_REG_BANK_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ts <= '0;
        end else if (load) begin
            ts <= ts_now;
        end
    end
`else
    logic unused_ts_now;
    assign unused_ts_now = ^ts_now;
    assign ts            = '0;
`endif

endmodule

// File: rtl/opb_register_bank_s2p.sv
// OPB slave exposing C_NUM_CH captured user-data channels with sticky status.
// Optional per-channel capture timestamps: define OPB_REG_BANK_TIMESTAMP_EN.
module opb_register_bank_s2p
    import opb_reg_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108_0700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108_07FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_CH     = 4,
    parameter int          C_DATA_WIDTH = 32
) (
    input  logic                               OPB_Clk,
    input  logic                               OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]            OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]          OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]            OPB_DBus,
    input  logic                               OPB_RNW,
    input  logic                               OPB_select,
    input  logic                               OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]            Sl_DBus,
    output logic                               Sl_errAck,
    output logic                               Sl_retry,
    output logic                               Sl_toutSup,
    output logic                               Sl_xferAck,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]   user_data_in,
    input  logic [C_NUM_CH-1:0]                user_valid
);

    localparam logic [31:0] TS_BASE = OFF_CH_BASE + 32'(4 * C_NUM_CH);

    bus_state_t state_q, state_d;
    logic [31:0] off_d, off_q;
    logic        rnw_q;
    logic        snap_q;
    logic        in_window;
    logic        ack;
    logic        ctrl_wr;
    logic        ovf_clr;
    logic        rd_ch;
    logic [31:0] ch_rel, ch_idx, ts_rel, ts_idx;
    logic        is_ch, is_ts;
    logic [31:0] rdata;
    logic [31:0] cycle_cnt;

    logic [C_DATA_WIDTH-1:0] ch_data [C_NUM_CH];
    logic [31:0]             ch_ts   [C_NUM_CH];
    logic [C_NUM_CH-1:0]     valid_vec, ovf_vec, rd_clr;

    assign in_window = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    assign off_d     = OPB_ABus - C_BASEADDR;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        Sl_xferAck = 1'b0;
        case (state_q)
            IDLE: if (OPB_select && in_window) state_d = ACK;
            ACK: begin
                Sl_xferAck = 1'b1;
                state_d    = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q <= IDLE;
            off_q   <= '0;
            rnw_q   <= 1'b0;
            snap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == ACK) begin
                off_q <= off_d;
                rnw_q <= OPB_RNW;
            end
            // Snapshot lands one cycle after the CTRL write is acknowledged
            snap_q <= ctrl_wr & OPB_DBus[CTRL_SNAP_BIT];
        end
    end

`ifdef OPB_REG_BANK_TIMESTAMP_EN
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = '0;
`endif

    assign ack     = (state_q == ACK);
    assign ctrl_wr = ack && !rnw_q && (off_q == OFF_CTRL) && OPB_BE[CTRL_BE_LANE];
    assign ovf_clr = ctrl_wr & OPB_DBus[CTRL_OVF_CLR_BIT];

    assign ch_rel = off_q - OFF_CH_BASE;
    assign ch_idx = {2'b00, ch_rel[31:2]};
    assign is_ch  = (off_q >= OFF_CH_BASE) && (ch_idx < 32'(C_NUM_CH));
    assign ts_rel = off_q - TS_BASE;
    assign ts_idx = {2'b00, ts_rel[31:2]};
    assign is_ts  = (off_q >= TS_BASE) && (ts_idx < 32'(C_NUM_CH));
    assign rd_ch  = ack && rnw_q && is_ch;

    for (genvar i = 0; i < C_NUM_CH; i++) begin : g_chan
        assign rd_clr[i] = rd_ch && (ch_idx == 32'(i));

        opb_reg_bank_chan #(
            .W (C_DATA_WIDTH)
        ) u_chan (
            .clk      (OPB_Clk),
            .rst      (OPB_Rst),
            .load     (user_valid[i] | snap_q),
            .read_clr (rd_clr[i]),
            .ovf_clr  (ovf_clr),
            .data_in  (user_data_in[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .ts_now   (cycle_cnt),
            .data     (ch_data[i]),
            .valid    (valid_vec[i]),
            .ovf      (ovf_vec[i]),
            .ts       (ch_ts[i])
        );
    end

    // Read data is driven only while acking a read; everything else returns 0
    always_comb begin
        rdata = '0;
        if (ack && rnw_q) begin
            if (off_q == OFF_VALID) rdata = 32'(valid_vec);
            if (off_q == OFF_OVF)   rdata = 32'(ovf_vec);
            if (off_q == OFF_INFO)  rdata = {16'(C_NUM_CH), 16'(C_DATA_WIDTH)};
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (is_ch && ch_idx == 32'(i)) rdata = 32'(ch_data[i]);
                if (is_ts && ts_idx == 32'(i)) rdata = ch_ts[i];
            end
        end
    end

    assign Sl_DBus    = rdata;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29], ch_rel[1:0], ts_rel[1:0]};

endmodule
